rv_iopmp_err_recorder: RTL and testbench



---
 rtl/rv_iopmp_pkg.sv | 38 +++
 rtl/rv_iopmp_err_recorder_if.sv | 49 ++++
 rtl/rv_iopmp_err_recorder.sv | 147 ++++++++++++++
 tb/tb_rv_iopmp_err_recorder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iopmp_pkg.sv
// Shared types and encodings for the IOPMP error-record block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_iopmp_pkg;

    // Access type of the faulting transaction
    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_EXEC  = 2'd3
    } access_t;

    // Error-type encodings reported by the decision logic
    localparam logic [2:0] ETYPE_NONE          = 3'd0;
    localparam logic [2:0] ETYPE_ILLEGAL_READ  = 3'd1;
    localparam logic [2:0] ETYPE_ILLEGAL_WRITE = 3'd2;
    localparam logic [2:0] ETYPE_ILLEGAL_EXEC  = 3'd3;
    localparam logic [2:0] ETYPE_PARTIAL_HIT   = 3'd4;
    localparam logic [2:0] ETYPE_NOT_HIT       = 3'd5;
    localparam logic [2:0] ETYPE_UNKNOWN_SID   = 3'd6;

    // Recorder FSM; any state other than IDLE means a record is valid
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MSI_REQ = 2'd1,
        ST_HELD    = 2'd2
    } err_state_e;

    // Fixed-width part of the error record. SID and address widths are
    // module parameters, so those fields are held beside this struct.
    typedef struct packed {
        logic [2:0]  etype;
        access_t     ttype;
        logic [15:0] eid;
    } err_info_t;

endpackage

// File: rtl/rv_iopmp_err_recorder_if.sv
// Error-report, software-control and record bus of the IOPMP error recorder.
// Latency: n/a (wiring only); names follow the recorder's port view.
// Backpressure: none on error strobes; the MSI request waits on msi_ack_i.
interface rv_iopmp_err_recorder_if
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned SID_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LOST_CNT_WIDTH = 8
);
    // Error report from the decision logic
    logic                      err_valid_i;
    logic [2:0]                err_type_i;
    logic [15:0]               err_entry_index_i;
    logic [SID_WIDTH-1:0]      err_sid_i;
    logic [ADDR_WIDTH-1:0]     err_addr_i;
    access_t                   err_access_i;
    // ERR_CFG and software control
    logic                      ie_i;
    logic                      msi_en_i;
    logic                      clr_i;
    // Recorded error
    logic                      err_v_o;
    logic [2:0]                err_etype_o;
    access_t                   err_ttype_o;
    logic [15:0]               err_eid_o;
    logic [SID_WIDTH-1:0]      err_sid_o;
    logic [ADDR_WIDTH-1:0]     err_addr_o;
    logic [LOST_CNT_WIDTH-1:0] err_lost_cnt_o;
    // Interrupt signalling
    logic                      wsi_irq_o;
    logic                      msi_req_o;
    logic                      msi_ack_i;

    modport master (
        output err_valid_i, err_type_i, err_entry_index_i, err_sid_i, err_addr_i,
               err_access_i, ie_i, msi_en_i, clr_i, msi_ack_i,
        input  err_v_o, err_etype_o, err_ttype_o, err_eid_o, err_sid_o, err_addr_o,
               err_lost_cnt_o, wsi_irq_o, msi_req_o
    );

    modport slave (
        input  err_valid_i, err_type_i, err_entry_index_i, err_sid_i, err_addr_i,
               err_access_i, ie_i, msi_en_i, clr_i, msi_ack_i,
        output err_v_o, err_etype_o, err_ttype_o, err_eid_o, err_sid_o, err_addr_o,
               err_lost_cnt_o, wsi_irq_o, msi_req_o
    );

endinterface

// File: rtl/rv_iopmp_err_recorder.sv
// Captures the first IOPMP error into a record, counts errors lost while held, raises WSI/MSI.
// Latency: record visible 1 cycle after the strobe; wsi_irq_o 1 cycle after err_v_o.
// Backpressure: none on err_valid_i (extra errors are counted); MSI request held until ack (RV_IOPMP_ERR_MSI_EN).
module rv_iopmp_err_recorder
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned SID_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LOST_CNT_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    rv_iopmp_err_recorder_if.slave bus
);

    err_state_e                state_q, state_d;
    err_info_t                 info_q, info_d;
    logic [SID_WIDTH-1:0]      sid_q, sid_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [LOST_CNT_WIDTH-1:0] lost_q, lost_d;
    logic [LOST_CNT_WIDTH-1:0] lost_sat;
    logic                      clr_pend_q, clr_pend_d;
    logic                      wsi_q, wsi_d;
    logic                      err_v;
    logic                      capture;

    assign err_v = (state_q != ST_IDLE);

    // Lost counter plus one, sticking at all-ones
    assign lost_sat = (lost_q == {LOST_CNT_WIDTH{1'b1}}) ? lost_q
                                                         : lost_q + LOST_CNT_WIDTH'(1);

    // Next-state, record capture and lost-count update
    always_comb begin
        state_d    = state_q;
        info_d     = info_q;
        sid_d      = sid_q;
        addr_d     = addr_q;
        lost_d     = lost_q;
        clr_pend_d = clr_pend_q;
        capture    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                capture = bus.err_valid_i;
            end
            ST_HELD: begin
                if (bus.clr_i) begin
                    // Clear and a new error together: the new error is recorded
                    lost_d = '0;
                    if (bus.err_valid_i) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.err_valid_i) begin
                    lost_d = lost_sat;
                end
            end
`ifdef RV_IOPMP_ERR_MSI_EN
            ST_MSI_REQ: begin
                // Record is frozen; a clear is remembered until the write is acked
                if (bus.err_valid_i) begin
                    lost_d = lost_sat;
                end
                if (bus.clr_i) begin
                    clr_pend_d = 1'b1;
                end
                if (bus.msi_ack_i) begin
                    clr_pend_d = 1'b0;
                    if (clr_pend_q || bus.clr_i) begin
                        state_d = ST_IDLE;
                        lost_d  = '0;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            info_d.etype = bus.err_type_i;
            info_d.ttype = bus.err_access_i;
            info_d.eid   = bus.err_entry_index_i;
            sid_d        = bus.err_sid_i;
            addr_d       = bus.err_addr_i;
`ifdef RV_IOPMP_ERR_MSI_EN
            state_d      = bus.msi_en_i ? ST_MSI_REQ : ST_HELD;
`else
            state_d      = ST_HELD;
`endif
        end
    end

    // Wired interrupt follows the record-valid bit one cycle later
    always_comb begin
`ifdef RV_IOPMP_ERR_MSI_EN
        wsi_d = err_v & bus.ie_i & ~bus.msi_en_i;
`else
        wsi_d = err_v & bus.ie_i;
`endif
    end

    // State and record registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            info_q     <= '0;
            sid_q      <= '0;
            addr_q     <= '0;
            lost_q     <= '0;
            clr_pend_q <= 1'b0;
            wsi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            info_q     <= info_d;
            sid_q      <= sid_d;
            addr_q     <= addr_d;
            lost_q     <= lost_d;
            clr_pend_q <= clr_pend_d;
            wsi_q      <= wsi_d;
        end
    end

`ifdef RV_IOPMP_ERR_MSI_EN
    assign bus.msi_req_o = (state_q == ST_MSI_REQ);
`else
    // Without MSI support the select and acknowledge have no effect
    logic unused_msi;
    assign unused_msi    = bus.msi_ack_i ^ bus.msi_en_i;
    assign bus.msi_req_o = 1'b0;
`endif

    assign bus.err_v_o        = err_v;
    assign bus.err_etype_o    = info_q.etype;
    assign bus.err_ttype_o    = info_q.ttype;
    assign bus.err_eid_o      = info_q.eid;
    assign bus.err_sid_o      = sid_q;
    assign bus.err_addr_o     = addr_q;
    assign bus.err_lost_cnt_o = lost_q;
    assign bus.wsi_irq_o      = wsi_q;

endmodule

// File: tb/tb_rv_iopmp_err_recorder.sv
// Self-checking bench for rv_iopmp_err_recorder: vector table with expected-record queue,
// plus hand sequences for counter saturation, MSI handshake and mid-operation reset.
// Works with or without RV_IOPMP_ERR_MSI_EN defined.
module tb_rv_iopmp_err_recorder;
    import rv_iopmp_pkg::*;

    logic clk_i;
    logic rst_ni;

    rv_iopmp_err_recorder_if #(.SID_WIDTH(8), .ADDR_WIDTH(64), .LOST_CNT_WIDTH(8)) bus ();

    rv_iopmp_err_recorder #(
        .SID_WIDTH(8), .ADDR_WIDTH(64), .LOST_CNT_WIDTH(8)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        vld;
        logic [2:0]  et;
        logic [15:0] eid;
        logic [7:0]  sid;
        logic [63:0] addr;
        access_t     acc;
        logic        ie;
        logic        clr;
    } in_t;

    typedef struct {
        logic        v;
        logic [2:0]  et;
        access_t     tt;
        logic [15:0] eid;
        logic [7:0]  sid;
        logic [63:0] addr;
        logic [7:0]  lost;
        logic        wsi;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];
    out_t exp_q[$];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic in_t mk_in(logic vld, logic [2:0] et, logic [15:0] eid, logic [7:0] sid,
                                  logic [63:0] addr, access_t acc, logic ie, logic clr);
        in_t x;
        x.vld = vld; x.et = et; x.eid = eid; x.sid = sid;
        x.addr = addr; x.acc = acc; x.ie = ie; x.clr = clr;
        return x;
    endfunction

    function automatic out_t mk_out(logic v, logic [2:0] et, access_t tt, logic [15:0] eid,
                                    logic [7:0] sid, logic [63:0] addr, logic [7:0] lost, logic wsi);
        out_t y;
        y.v = v; y.et = et; y.tt = tt; y.eid = eid; y.sid = sid;
        y.addr = addr; y.lost = lost; y.wsi = wsi;
        return y;
    endfunction

    task automatic drive(input in_t x);
        bus.err_valid_i       = x.vld;
        bus.err_type_i        = x.et;
        bus.err_entry_index_i = x.eid;
        bus.err_sid_i         = x.sid;
        bus.err_addr_i        = x.addr;
        bus.err_access_i      = x.acc;
        bus.ie_i              = x.ie;
        bus.clr_i             = x.clr;
    endtask

    task automatic cmp_out(input string tag, input out_t e);
        chk({tag, ".v"},     {63'd0, bus.err_v_o},      {63'd0, e.v});
        chk({tag, ".etype"}, {61'd0, bus.err_etype_o},  {61'd0, e.et});
        chk({tag, ".ttype"}, {62'd0, bus.err_ttype_o},  {62'd0, e.tt});
        chk({tag, ".eid"},   {48'd0, bus.err_eid_o},    {48'd0, e.eid});
        chk({tag, ".sid"},   {56'd0, bus.err_sid_o},    {56'd0, e.sid});
        chk({tag, ".addr"},  bus.err_addr_o,            e.addr);
        chk({tag, ".lost"},  {56'd0, bus.err_lost_cnt_o}, {56'd0, e.lost});
        chk({tag, ".wsi"},   {63'd0, bus.wsi_irq_o},    {63'd0, e.wsi});
        chk({tag, ".msi"},   {63'd0, bus.msi_req_o},    64'd0);
    endtask

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, n_tot=%0d", n_tot);
        $fatal(1);
    end

    initial begin
        out_t e;
        in_t  idle_in;
        logic [63:0] addr_a, addr_b, addr_c, addr_d;

        addr_a = 64'h0000_0000_8000_1000;
        addr_b = 64'h0000_0000_0000_DEAD;
        addr_c = 64'h0000_0000_0000_1234;
        addr_d = 64'h0000_0000_0000_5678;
        idle_in = mk_in(0, 3'd0, 16'd0, 8'h00, 64'd0, ACC_NONE, 1, 0);

        // Vector table: one cycle each, expected outputs sampled after the edge
        vecs[0]  = '{i: idle_in,
                     o: mk_out(0, 3'd0, ACC_NONE, 16'd0, 8'h00, 64'd0, 8'd0, 0)};
        vecs[1]  = '{i: mk_in(1, ETYPE_ILLEGAL_WRITE, 16'd5, 8'h1A, addr_a, ACC_WRITE, 1, 0),
                     o: mk_out(1, ETYPE_ILLEGAL_WRITE, ACC_WRITE, 16'd5, 8'h1A, addr_a, 8'd0, 0)};
        vecs[2]  = '{i: idle_in,
                     o: mk_out(1, ETYPE_ILLEGAL_WRITE, ACC_WRITE, 16'd5, 8'h1A, addr_a, 8'd0, 1)};
        vecs[3]  = '{i: mk_in(1, ETYPE_NOT_HIT, 16'd7, 8'h22, addr_b, ACC_READ, 1, 0),
                     o: mk_out(1, ETYPE_ILLEGAL_WRITE, ACC_WRITE, 16'd5, 8'h1A, addr_a, 8'd1, 1)};
        vecs[4]  = '{i: mk_in(1, ETYPE_NOT_HIT, 16'd7, 8'h22, addr_b, ACC_READ, 1, 0),
                     o: mk_out(1, ETYPE_ILLEGAL_WRITE, ACC_WRITE, 16'd5, 8'h1A, addr_a, 8'd2, 1)};
        vecs[5]  = '{i: mk_in(1, ETYPE_NOT_HIT, 16'd7, 8'h22, addr_b, ACC_READ, 1, 0),
                     o: mk_out(1, ETYPE_ILLEGAL_WRITE, ACC_WRITE, 16'd5, 8'h1A, addr_a, 8'd3, 1)};
        vecs[6]  = '{i: mk_in(0, 3'd0, 16'd0, 8'h00, 64'd0, ACC_NONE, 1, 1),
                     o: mk_out(0, ETYPE_ILLEGAL_WRITE, ACC_WRITE, 16'd5, 8'h1A, addr_a, 8'd0, 1)};
        vecs[7]  = '{i: idle_in,
                     o: mk_out(0, ETYPE_ILLEGAL_WRITE, ACC_WRITE, 16'd5, 8'h1A, addr_a, 8'd0, 0)};
        vecs[8]  = '{i: mk_in(1, ETYPE_ILLEGAL_READ, 16'd3, 8'h44, addr_c, ACC_READ, 1, 0),
                     o: mk_out(1, ETYPE_ILLEGAL_READ, ACC_READ, 16'd3, 8'h44, addr_c, 8'd0, 0)};
        vecs[9]  = '{i: mk_in(1, ETYPE_NOT_HIT, 16'd7, 8'h22, addr_b, ACC_READ, 1, 0),
                     o: mk_out(1, ETYPE_ILLEGAL_READ, ACC_READ, 16'd3, 8'h44, addr_c, 8'd1, 1)};
        vecs[10] = '{i: mk_in(1, ETYPE_PARTIAL_HIT, 16'd9, 8'h55, addr_d, ACC_EXEC, 1, 1),
                     o: mk_out(1, ETYPE_PARTIAL_HIT, ACC_EXEC, 16'd9, 8'h55, addr_d, 8'd0, 1)};
        vecs[11] = '{i: mk_in(0, 3'd0, 16'd0, 8'h00, 64'd0, ACC_NONE, 0, 0),
                     o: mk_out(1, ETYPE_PARTIAL_HIT, ACC_EXEC, 16'd9, 8'h55, addr_d, 8'd0, 0)};
        vecs[12] = '{i: mk_in(0, 3'd0, 16'd0, 8'h00, 64'd0, ACC_NONE, 0, 1),
                     o: mk_out(0, ETYPE_PARTIAL_HIT, ACC_EXEC, 16'd9, 8'h55, addr_d, 8'd0, 0)};

        // Reset state
        rst_ni        = 1'b0;
        bus.msi_en_i  = 1'b0;
        bus.msi_ack_i = 1'b0;
        drive(idle_in);
        #3;
        cmp_out("reset", mk_out(0, 3'd0, ACC_NONE, 16'd0, 8'h00, 64'd0, 8'd0, 0));
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Table run through the expected-record queue
        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].i);
            exp_q.push_back(vecs[k].o);
            step();
            if (exp_q.size() == 0) begin
                chk($sformatf("vec%0d.queue", k), 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                cmp_out($sformatf("vec%0d", k), e);
            end
        end

        // Lost counter saturation
        drive(mk_in(1, ETYPE_ILLEGAL_EXEC, 16'h0100, 8'h77, 64'hFFFF_0000_0000_0008, ACC_READ, 1, 0));
        step();
        chk("sat.capture_v", {63'd0, bus.err_v_o}, 64'd1);
        drive(mk_in(1, ETYPE_NOT_HIT, 16'h0AAA, 8'h11, 64'h42, ACC_WRITE, 1, 0));
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 253) chk("sat.lost_254", {56'd0, bus.err_lost_cnt_o}, 64'hFE);
            if (i == 254) chk("sat.lost_255", {56'd0, bus.err_lost_cnt_o}, 64'hFF);
        end
        chk("sat.lost_300", {56'd0, bus.err_lost_cnt_o}, 64'hFF);
        chk("sat.eid_kept", {48'd0, bus.err_eid_o}, 64'h0100);
        chk("sat.addr_kept", bus.err_addr_o, 64'hFFFF_0000_0000_0008);
        drive(mk_in(0, 3'd0, 16'd0, 8'h00, 64'd0, ACC_NONE, 1, 1));
        step();
        chk("sat.clr_v", {63'd0, bus.err_v_o}, 64'd0);
        chk("sat.clr_lost", {56'd0, bus.err_lost_cnt_o}, 64'd0);
        drive(idle_in);
        step();

`ifdef RV_IOPMP_ERR_MSI_EN
        // MSI handshake: ack delayed, clear pulsed mid-request
        bus.msi_en_i = 1'b1;
        drive(mk_in(1, ETYPE_NOT_HIT, 16'd12, 8'h33, 64'h2000, ACC_READ, 1, 0));
        step();
        chk("msi.req_rise", {63'd0, bus.msi_req_o}, 64'd1);
        chk("msi.v", {63'd0, bus.err_v_o}, 64'd1);
        for (int c = 1; c <= 4; c++) begin
            drive(mk_in(0, 3'd0, 16'd0, 8'h00, 64'd0, ACC_NONE, 1, (c == 2)));
            step();
            chk($sformatf("msi.req_hold%0d", c), {63'd0, bus.msi_req_o}, 64'd1);
            chk($sformatf("msi.eid_hold%0d", c), {48'd0, bus.err_eid_o}, 64'd12);
            chk($sformatf("msi.wsi%0d", c), {63'd0, bus.wsi_irq_o}, 64'd0);
        end
        drive(idle_in);
        bus.msi_ack_i = 1'b1;
        step();
        bus.msi_ack_i = 1'b0;
        chk("msi.ack_req", {63'd0, bus.msi_req_o}, 64'd0);
        chk("msi.ack_idle_v", {63'd0, bus.err_v_o}, 64'd0);
        chk("msi.ack_wsi", {63'd0, bus.wsi_irq_o}, 64'd0);
        step();
        chk("msi.after_wsi", {63'd0, bus.wsi_irq_o}, 64'd0);
        // Ack in the first request cycle is accepted
        drive(mk_in(1, ETYPE_ILLEGAL_READ, 16'd13, 8'h34, 64'h3000, ACC_READ, 1, 0));
        step();
        drive(idle_in);
        bus.msi_ack_i = 1'b1;
        step();
        chk("msi.fast_ack_req", {63'd0, bus.msi_req_o}, 64'd0);
        chk("msi.fast_ack_held", {63'd0, bus.err_v_o}, 64'd1);
        // Ack outside the request state is ignored
        step();
        bus.msi_ack_i = 1'b0;
        chk("msi.stray_ack_v", {63'd0, bus.err_v_o}, 64'd1);
        chk("msi.held_wsi", {63'd0, bus.wsi_irq_o}, 64'd0);
        drive(mk_in(0, 3'd0, 16'd0, 8'h00, 64'd0, ACC_NONE, 1, 1));
        step();
        chk("msi.clr_v", {63'd0, bus.err_v_o}, 64'd0);
        drive(idle_in);
        step();
`else
        // Without MSI support, msi_en_i has no effect
        bus.msi_en_i = 1'b1;
        drive(mk_in(1, ETYPE_NOT_HIT, 16'd12, 8'h33, 64'h2000, ACC_READ, 1, 0));
        step();
        chk("nomsi.req", {63'd0, bus.msi_req_o}, 64'd0);
        chk("nomsi.v", {63'd0, bus.err_v_o}, 64'd1);
        drive(idle_in);
        bus.msi_ack_i = 1'b1;
        step();
        bus.msi_ack_i = 1'b0;
        chk("nomsi.wsi", {63'd0, bus.wsi_irq_o}, 64'd1);
        chk("nomsi.req2", {63'd0, bus.msi_req_o}, 64'd0);
        chk("nomsi.held_v", {63'd0, bus.err_v_o}, 64'd1);
        drive(mk_in(0, 3'd0, 16'd0, 8'h00, 64'd0, ACC_NONE, 1, 1));
        step();
        chk("nomsi.clr_v", {63'd0, bus.err_v_o}, 64'd0);
        drive(idle_in);
        step();
`endif

        // Asynchronous reset with a live record
`ifdef RV_IOPMP_ERR_MSI_EN
        bus.msi_en_i = 1'b1;
`else
        bus.msi_en_i = 1'b0;
`endif
        drive(mk_in(1, ETYPE_UNKNOWN_SID, 16'd21, 8'h66, 64'h4000, ACC_WRITE, 1, 0));
        step();
        step();
        chk("rst.pre_lost", {56'd0, bus.err_lost_cnt_o}, 64'd1);
`ifdef RV_IOPMP_ERR_MSI_EN
        chk("rst.pre_req", {63'd0, bus.msi_req_o}, 64'd1);
`else
        chk("rst.pre_wsi", {63'd0, bus.wsi_irq_o}, 64'd1);
`endif
        drive(idle_in);
        #2;
        rst_ni = 1'b0;
        #1;
        cmp_out("rst.async", mk_out(0, 3'd0, ACC_NONE, 16'd0, 8'h00, 64'd0, 8'd0, 0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        bus.msi_en_i = 1'b0;
        drive(mk_in(1, ETYPE_UNKNOWN_SID, 16'h0042, 8'h0C, 64'h1000, ACC_EXEC, 1, 0));
        step();
        drive(idle_in);
        cmp_out("rst.recapture", mk_out(1, ETYPE_UNKNOWN_SID, ACC_EXEC, 16'h0042, 8'h0C, 64'h1000, 8'd0, 0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
